// File: rtl/dll_rx_tlp_demux_pkg.sv
// Shared types and error codes for the receive-side DLL deframer.
package dll_rx_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    DATA = 2'd1,
    LCRC = 2'd2
  } state_e;

  localparam logic [1:0] ERR_END_EARLY = 2'b01;
  localparam logic [1:0] ERR_LEN_ZERO  = 2'b10;
  localparam logic [1:0] ERR_NO_END    = 2'b11;

endpackage

// File: rtl/dll_rx_tlp_demux.sv
// Receive-side DLL deframer: splits {SEQ, data beats, LCRC+end} frames,
// forwards data beats, holds seq/len/LCRC, flags malformed frames.
module dll_rx_tlp_demux
  import dll_rx_pkg::*;
#(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned SEQ_W  = 12,
  parameter int unsigned LEN_W  = 6,
  parameter int unsigned CRC_W  = 32,
  parameter int unsigned CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  input  logic              rx_end,
  input  logic [LEN_W-1:0]  rx_len,
  output logic [DATA_W-1:0] tlp_out,
  output logic              tlp_out_valid,
  output logic              tlp_out_first,
  output logic              tlp_out_last,
  output logic [SEQ_W-1:0]  seq_num_out,
  output logic [LEN_W-1:0]  tlp_len_out,
  output logic [CRC_W-1:0]  lcrc_out,
  output logic              frame_done,
  output logic              frame_err,
  output logic [1:0]        frame_err_code,
  output logic [CNT_W-1:0]  pkt_count
);

  state_e             state;
  state_e             state_d;
  logic [LEN_W-1:0]   beat_cnt;
  logic [LEN_W-1:0]   beat_cnt_d;
  logic               is_last_c;

  logic [DATA_W-1:0]  tlp_out_d;
  logic               tlp_out_valid_d;
  logic               tlp_out_first_d;
  logic               tlp_out_last_d;
  logic [SEQ_W-1:0]   seq_num_d;
  logic [LEN_W-1:0]   tlp_len_d;
  logic [CRC_W-1:0]   lcrc_d;
  logic               frame_done_d;
  logic               frame_err_d;
  logic [1:0]         frame_err_code_d;
  logic [CNT_W-1:0]   pkt_count_d;

  // Current data beat is the final one of the frame.
  assign is_last_c = (beat_cnt == tlp_len_out - LEN_W'(1));

  // State, beat counter and all registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state          <= IDLE;
      beat_cnt       <= '0;
      tlp_out        <= '0;
      tlp_out_valid  <= 1'b0;
      tlp_out_first  <= 1'b0;
      tlp_out_last   <= 1'b0;
      seq_num_out    <= '0;
      tlp_len_out    <= '0;
      lcrc_out       <= '0;
      frame_done     <= 1'b0;
      frame_err      <= 1'b0;
      frame_err_code <= '0;
      pkt_count      <= '0;
    end else begin
      state          <= state_d;
      beat_cnt       <= beat_cnt_d;
      tlp_out        <= tlp_out_d;
      tlp_out_valid  <= tlp_out_valid_d;
      tlp_out_first  <= tlp_out_first_d;
      tlp_out_last   <= tlp_out_last_d;
      seq_num_out    <= seq_num_d;
      tlp_len_out    <= tlp_len_d;
      lcrc_out       <= lcrc_d;
      frame_done     <= frame_done_d;
      frame_err      <= frame_err_d;
      frame_err_code <= frame_err_code_d;
      pkt_count      <= pkt_count_d;
    end
  end

  // Frame-position transitions; idle cycles never move the FSM.
  always_comb begin
    state_d = state;
    if (rx_valid) begin
      case (state)
        IDLE: if (!rx_end && (rx_len != '0)) state_d = DATA;
        DATA: begin
          if (rx_end)         state_d = IDLE;
          else if (is_last_c) state_d = LCRC;
        end
        LCRC:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  // Next values of outputs and beat counter; pulses default low, the rest hold.
  always_comb begin
    beat_cnt_d       = beat_cnt;
    tlp_out_d        = tlp_out;
    tlp_out_valid_d  = 1'b0;
    tlp_out_first_d  = 1'b0;
    tlp_out_last_d   = 1'b0;
    seq_num_d        = seq_num_out;
    tlp_len_d        = tlp_len_out;
    lcrc_d           = lcrc_out;
    frame_done_d     = 1'b0;
    frame_err_d      = 1'b0;
    frame_err_code_d = frame_err_code;
    pkt_count_d      = pkt_count;
    if (rx_valid) begin
      case (state)
        IDLE: begin
          if (rx_end) begin
            frame_err_d      = 1'b1;
            frame_err_code_d = ERR_END_EARLY;
          end else if (rx_len == '0) begin
            frame_err_d      = 1'b1;
            frame_err_code_d = ERR_LEN_ZERO;
          end else begin
            seq_num_d  = rx_data[SEQ_W-1:0];
            tlp_len_d  = rx_len;
            beat_cnt_d = '0;
          end
        end
        DATA: begin
          if (rx_end) begin
            frame_err_d      = 1'b1;
            frame_err_code_d = ERR_END_EARLY;
          end else begin
            tlp_out_d       = rx_data;
            tlp_out_valid_d = 1'b1;
            tlp_out_first_d = (beat_cnt == '0);
            tlp_out_last_d  = is_last_c;
            beat_cnt_d      = beat_cnt + LEN_W'(1);
          end
        end
        LCRC: begin
          if (rx_end) begin
            lcrc_d       = rx_data[CRC_W-1:0];
            frame_done_d = 1'b1;
            pkt_count_d  = pkt_count + CNT_W'(1);
          end else begin
            frame_err_d      = 1'b1;
            frame_err_code_d = ERR_NO_END;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
